// File: rtl/call_stack.sv
// Hardware call/return LIFO with tagged entries, byte-addressed SP and sticky errors.
// Latency: single cycle; every update is visible on outputs the cycle after the sampling edge.
// Backpressure: none; illegal push (full) / pop (empty) is dropped and flagged in ovf/unf.
module call_stack #(
    parameter int          WIDTH   = 32,
    parameter int          DEPTH   = 16,
    parameter int          TAG_W   = 4,
    parameter logic [15:0] SP_BASE = 16'hFFFC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic                       err_clr,
    input  logic [WIDTH-1:0]           push_data,
    input  logic [TAG_W-1:0]           push_tag,
    output logic [WIDTH-1:0]           top_data,
    output logic [TAG_W-1:0]           top_tag,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [15:0]                sp,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       unf
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);
    localparam int BYTES = WIDTH / 8;

    logic [WIDTH-1:0] mem_dat [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [CW-1:0] count_nxt;
    logic          ovf_set;
    logic          unf_set;
    logic [IW-1:0] top_idx;
    logic [15:0]   sp_dec;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign top_idx = IW'(count - CW'(1));
    assign sp_dec  = 16'(32'(count) * BYTES);
    assign sp      = SP_BASE - sp_dec;

    assign top_data = empty ? '0 : mem_dat[top_idx];
    assign top_tag  = empty ? '0 : mem_tag[top_idx];

    // flush dominates push/pop; push+pop on empty degenerates to a push that still flags underflow
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = IW'(count);
        count_nxt = count;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        wr_en     = 1'b1;
                        count_nxt = count + CW'(1);
                    end
                end
                2'b01: begin
                    if (empty) unf_set = 1'b1;
                    else       count_nxt = count - CW'(1);
                end
                2'b11: begin
                    wr_en = 1'b1;
                    if (empty) begin
                        wr_idx    = '0;
                        count_nxt = CW'(1);
                        unf_set   = 1'b1;
                    end else begin
                        wr_idx = top_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_set | (ovf & ~err_clr);
            unf   <= unf_set | (unf & ~err_clr);
        end
    end

    // Entry storage carries no reset; it is only observable through count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_dat[wr_idx] <= push_data;
            mem_tag[wr_idx] <= push_tag;
        end
    end
endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed scenarios plus randomized traffic against a queue model.
module tb_call_stack;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int TAG_W = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0, pop = 1'b0, flush = 1'b0, err_clr = 1'b0;
    logic [WIDTH-1:0] push_data = '0;
    logic [TAG_W-1:0] push_tag = '0;
    logic [WIDTH-1:0] top_data;
    logic [TAG_W-1:0] top_tag;
    logic [CW-1:0]    count;
    logic [15:0]      sp;
    logic             empty, full, ovf, unf;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] dat;
    } entry_t;

    entry_t mq[$];
    logic   m_ovf = 1'b0;
    logic   m_unf = 1'b0;

    call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .SP_BASE(16'hFFFC)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .err_clr(err_clr),
        .push_data(push_data), .push_tag(push_tag), .top_data(top_data), .top_tag(top_tag),
        .count(count), .sp(sp), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] exp_dat();
        return (mq.size() == 0) ? '0 : mq[$].dat;
    endfunction

    function automatic logic [TAG_W-1:0] exp_tag();
        return (mq.size() == 0) ? '0 : mq[$].tag;
    endfunction

    function automatic logic [15:0] exp_sp();
        return 16'(32'hFFFC - mq.size() * (WIDTH/8));
    endfunction

    // Reference behaviour: a LIFO as a queue, errors as sticky bits.
    task automatic model_step(input logic p, input logic po, input logic f, input logic e,
                              input logic [WIDTH-1:0] d, input logic [TAG_W-1:0] t);
        logic so = 1'b0, su = 1'b0;
        entry_t ent;
        ent.dat = d;
        ent.tag = t;
        if (f) begin
            mq.delete();
        end else if (p && po) begin
            if (mq.size() == 0) begin
                mq.push_back(ent);
                su = 1'b1;
            end else begin
                mq[mq.size()-1] = ent;
            end
        end else if (p) begin
            if (mq.size() == DEPTH) so = 1'b1;
            else mq.push_back(ent);
        end else if (po) begin
            if (mq.size() == 0) su = 1'b1;
            else void'(mq.pop_back());
        end
        m_ovf = so | (m_ovf & ~e);
        m_unf = su | (m_unf & ~e);
    endtask

    // Drive one cycle of inputs, advance past the edge, update the model; returns at edge+1.
    task automatic do_cycle(input logic p, input logic po, input logic f, input logic e,
                            input logic [WIDTH-1:0] d, input logic [TAG_W-1:0] t);
        push = p; pop = po; flush = f; err_clr = e; push_data = d; push_tag = t;
        @(posedge clk);
        model_step(p, po, f, e, d, t);
        #1;
    endtask

    task automatic test_reset();
        #2;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0)
            begin errors++; $display("FAIL reset_status count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
        checks++;
        if (sp !== 16'hFFFC || top_data !== '0 || top_tag !== '0)
            begin errors++; $display("FAIL reset_sp_top sp=%h top=%h tag=%h want fffc/0/0", sp, top_data, top_tag); end
        checks++;
        if (ovf !== 1'b0 || unf !== 1'b0)
            begin errors++; $display("FAIL reset_flags ovf=%b unf=%b want 0/0", ovf, unf); end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        do_cycle(0, 0, 0, 0, '0, '0);
        if (count !== '0 || empty !== 1'b1 || sp !== 16'hFFFC)
            begin errors++; $display("FAIL idle_after_reset count=%0d empty=%b sp=%h want 0/1/fffc", count, empty, sp); end
        checks++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) do_cycle(1, 0, 0, 0, 32'h100 + i, TAG_W'(i));
        if (full !== 1'b1 || count !== CW'(16) || sp !== 16'hFFBC)
            begin errors++; $display("FAIL fill_status full=%b count=%0d sp=%h want 1/16/ffbc", full, count, sp); end
        checks++;
        if (top_data !== 32'h10F || top_tag !== 4'hF)
            begin errors++; $display("FAIL fill_top top=%h tag=%h want 10f/f", top_data, top_tag); end
        checks++;
        do_cycle(1, 0, 0, 0, 32'hDEAD, 4'h7);
        if (ovf !== 1'b1 || top_data !== 32'h10F || count !== CW'(16))
            begin errors++; $display("FAIL overflow ovf=%b top=%h count=%0d want 1/10f/16", ovf, top_data, count); end
        checks++;
        for (int i = 0; i < 16; i++) begin
            if (top_data !== 32'h10F - i || top_tag !== TAG_W'(15 - i))
                begin errors++; $display("FAIL drain_order i=%0d top=%h tag=%h want %h/%h", i, top_data, top_tag, 32'h10F - i, 15 - i); end
            checks++;
            do_cycle(0, 1, 0, 0, '0, '0);
        end
        if (empty !== 1'b1 || count !== '0 || top_data !== '0 || unf !== 1'b0)
            begin errors++; $display("FAIL drain_empty empty=%b count=%0d top=%h unf=%b want 1/0/0/0", empty, count, top_data, unf); end
        checks++;
        do_cycle(0, 0, 0, 1, '0, '0);
        if (ovf !== 1'b0)
            begin errors++; $display("FAIL ovf_clear ovf=%b want 0", ovf); end
        checks++;
    endtask

    task automatic test_underflow_clr();
        do_cycle(0, 1, 0, 1, '0, '0);
        if (unf !== 1'b1 || count !== '0)
            begin errors++; $display("FAIL unf_set_wins unf=%b count=%0d want 1/0", unf, count); end
        checks++;
        do_cycle(0, 0, 0, 1, '0, '0);
        if (unf !== 1'b0)
            begin errors++; $display("FAIL unf_clear unf=%b want 0", unf); end
        checks++;
    endtask

    task automatic test_push_pop();
        do_cycle(1, 0, 0, 0, 32'h1, 4'h1);
        do_cycle(1, 0, 0, 0, 32'h2, 4'h2);
        do_cycle(1, 0, 0, 0, 32'hA, 4'hA);
        do_cycle(1, 1, 0, 0, 32'hB, 4'hB);
        if (top_data !== 32'hB || top_tag !== 4'hB || count !== CW'(3))
            begin errors++; $display("FAIL replace_mid top=%h tag=%h count=%0d want b/b/3", top_data, top_tag, count); end
        checks++;
        do_cycle(0, 1, 0, 0, '0, '0);
        if (top_data !== 32'h2 || count !== CW'(2))
            begin errors++; $display("FAIL replace_below top=%h count=%0d want 2/2", top_data, count); end
        checks++;
        do_cycle(0, 0, 1, 0, '0, '0);
        for (int i = 0; i < 16; i++) do_cycle(1, 0, 0, 0, 32'h200 + i, TAG_W'(i));
        do_cycle(1, 1, 0, 0, 32'hC, 4'hC);
        if (top_data !== 32'hC || count !== CW'(16) || ovf !== 1'b0 || full !== 1'b1)
            begin errors++; $display("FAIL replace_full top=%h count=%0d ovf=%b full=%b want c/16/0/1", top_data, count, ovf, full); end
        checks++;
        do_cycle(0, 0, 1, 0, '0, '0);
        do_cycle(1, 1, 0, 0, 32'hD, 4'hD);
        if (count !== CW'(1) || unf !== 1'b1 || top_data !== 32'hD || top_tag !== 4'hD)
            begin errors++; $display("FAIL pushpop_empty count=%0d unf=%b top=%h tag=%h want 1/1/d/d", count, unf, top_data, top_tag); end
        checks++;
        do_cycle(0, 0, 1, 1, '0, '0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) do_cycle(1, 0, 0, 0, 32'h300 + i, 4'h3);
        do_cycle(1, 0, 1, 0, 32'hEE, 4'hE);
        if (count !== '0 || sp !== 16'hFFFC || ovf !== 1'b0 || unf !== 1'b0 || empty !== 1'b1)
            begin errors++; $display("FAIL flush count=%0d sp=%h ovf=%b unf=%b empty=%b want 0/fffc/0/0/1", count, sp, ovf, unf, empty); end
        checks++;
        do_cycle(0, 1, 1, 0, '0, '0);
        if (unf !== 1'b0)
            begin errors++; $display("FAIL flush_masks_pop unf=%b want 0", unf); end
        checks++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) do_cycle(1, 0, 0, 0, 32'h400 + i, 4'h4);
        do_cycle(0, 1, 0, 0, '0, '0);
        do_cycle(0, 1, 0, 0, '0, '0);
        do_cycle(0, 0, 0, 0, '0, '0);
        if (count !== CW'(5) || unf !== 1'b0)
            begin errors++; $display("FAIL pre_reset count=%0d unf=%b want 5/0", count, unf); end
        checks++;
        do_cycle(1, 0, 0, 0, 32'h407, 4'h4);
        do_cycle(1, 0, 0, 0, 32'h408, 4'h4);
        // count is 7 here; a push is pending when reset hits mid-cycle
        push = 1'b1; push_data = 32'h999;
        #3 rst = 1'b1;
        #1;
        if (count !== '0 || empty !== 1'b1 || top_data !== '0 || sp !== 16'hFFFC || ovf !== 1'b0)
            begin errors++; $display("FAIL async_reset count=%0d empty=%b top=%h sp=%h ovf=%b want 0/1/0/fffc/0", count, empty, top_data, sp, ovf); end
        checks++;
        push = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        do_cycle(0, 0, 0, 0, '0, '0);
        if (count !== '0 || empty !== 1'b1)
            begin errors++; $display("FAIL after_release count=%0d empty=%b want 0/1", count, empty); end
        checks++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic p, po, f, e;
            p  = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            f  = ($urandom_range(0, 99) < 3);
            e  = ($urandom_range(0, 99) < 10);
            do_cycle(p, po, f, e, $urandom, TAG_W'($urandom));
            if (count !== CW'(mq.size()) || top_data !== exp_dat() || top_tag !== exp_tag())
                begin errors++; $display("FAIL rand_state n=%0d count=%0d top=%h tag=%h want %0d/%h/%h", n, count, top_data, top_tag, mq.size(), exp_dat(), exp_tag()); end
            checks++;
            if (sp !== exp_sp() || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH))
                begin errors++; $display("FAIL rand_status n=%0d sp=%h empty=%b full=%b want sp %h", n, sp, empty, full, exp_sp()); end
            checks++;
            if (ovf !== m_ovf || unf !== m_unf)
                begin errors++; $display("FAIL rand_flags n=%0d ovf=%b unf=%b want %b/%b", n, ovf, unf, m_ovf, m_unf); end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_underflow_clr();
        test_push_pop();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout no completion within time limit");
        $fatal(1, "timeout");
    end
endmodule
